mix_columns_iter: RTL and testbench

- Sequential, parametrised successor to the combinational AES MixColumns stage. One block serves both cipher directions: forward MixColumns and inverse (InvMixColumns) are selected per transaction.
- Processes the 128-bit state COLS_PER_CYCLE columns per clock, trading area against latency.
- Sits between ShiftRows/InvShiftRows and AddRoundKey in the dual-mode round datapath.
- Uses a valid/ready handshake on both sides, so the round controller can stall it.

---
 rtl/aes_pkg.sv | 25 ++
 rtl/mix_single_column.sv | 43 ++++
 rtl/mix_columns_iter.sv | 102 ++++++++++
 tb/tb_mix_columns_iter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, cipher-direction enum and the GF(2^8) xtime helper
// used by the MixColumns datapath.
package aes_pkg;

    localparam int         AES_NUM_COLS = 4;
    localparam int         AES_COL_W    = 32;
    localparam logic [7:0] AES_POLY_RED = 8'h1B;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 32-bit column
// (row 0 in the MSB byte).
module mix_single_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] i_col,
    input  aes_mode_e            i_mode,
    output logic [AES_COL_W-1:0] o_col
);

    logic [7:0] w_a  [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_a[i]  = i_col[31-8*i -: 8];
            w_x2[i] = xtime(w_a[i]);
            w_x4[i] = xtime(w_x2[i]);
            w_x8[i] = xtime(w_x4[i]);
        end
    end

    // Inverse coefficients built from powers of x: 0e=8+4+2, 0b=8+2+1, 0d=8+4+1, 09=8+1.
    always_comb begin
        o_col = '0;
        for (int i = 0; i < 4; i++) begin
            if (i_mode == MODE_ENC) begin
                o_col[31-8*i -: 8] = w_x2[i]
                                   ^ (w_x2[(i+1)%4] ^ w_a[(i+1)%4])
                                   ^ w_a[(i+2)%4]
                                   ^ w_a[(i+3)%4];
            end else begin
                o_col[31-8*i -: 8] = (w_x8[i] ^ w_x4[i] ^ w_x2[i])
                                   ^ (w_x8[(i+1)%4] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4])
                                   ^ (w_x8[(i+2)%4] ^ w_x4[(i+2)%4] ^ w_a[(i+2)%4])
                                   ^ (w_x8[(i+3)%4] ^ w_a[(i+3)%4]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative dual-direction AES MixColumns: transforms COLS_PER_CYCLE columns
// per clock behind valid/ready handshakes on both sides.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int NUM_COLS       = AES_NUM_COLS
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) || NUM_COLS != 4) begin : g_bad_param
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4 and NUM_COLS must be 4");
        end
    endgenerate

    mc_state_e            r_state;
    mc_state_e            w_state_nxt;
    logic [1:0]           r_col_cnt;
    aes_mode_e            r_mode;
    logic [AES_COL_W-1:0] r_src  [NUM_COLS];
    logic [AES_COL_W-1:0] r_dout [NUM_COLS];

    logic                 w_accept;
    logic                 w_last;
    logic [1:0]           w_idx     [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] w_col_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0] w_col_out [COLS_PER_CYCLE];

    // in_ready is forced low while reset is held so nothing is accepted then.
    assign in_ready  = rst_n && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = ({1'b0, r_col_cnt} + 3'(COLS_PER_CYCLE)) == 3'(NUM_COLS);
    assign data_out  = {r_dout[0], r_dout[1], r_dout[2], r_dout[3]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_last)   w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = w_accept ? ST_BUSY : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Column group select and transform lanes.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign w_idx[g]    = r_col_cnt + 2'(g);
        assign w_col_in[g] = r_src[w_idx[g]];

        mix_single_column u_col (
            .i_col  (w_col_in[g]),
            .i_mode (r_mode),
            .o_col  (w_col_out[g])
        );
    end

    // Source capture needs no reset: it is only read after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                r_src[c] <= data_in[127-32*c -: 32];
            end
            r_mode <= aes_mode_e'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_cnt <= 2'd0;
            for (int c = 0; c < NUM_COLS; c++) begin
                r_dout[c] <= '0;
            end
        end else if (w_accept) begin
            r_col_cnt <= 2'd0;
        end else if (r_state == ST_BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                r_dout[w_idx[g]] <= w_col_out[g];
            end
            r_col_cnt <= r_col_cnt + 2'(COLS_PER_CYCLE);
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// checked against a matrix-level GF(2^8) model plus literal AES vectors.
module tb_mix_columns_iter;

    localparam logic [127:0] S_PLAIN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] S_MIX    = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COLV_IN  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] COLV_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam int LAT [3] = '{4, 2, 1};

    logic         clk = 1'b0;
    logic         rst_n     [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         mode      [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] din       [3];
    logic [127:0] dout      [3];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mode(mode[0]), .data_in(din[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .data_out(dout[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mode(mode[1]), .data_in(din[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .data_out(dout[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .mode(mode[2]), .data_in(din[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .data_out(dout[2]));

    // Reference: generic GF(2^8) product and matrix-times-column.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        logic [7:0] b;
        p = 8'h00; a = x; b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] res;
        res = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(coef[j], a[(i+j)%4]);
                res[127-32*c-8*i -: 8] = b;
            end
        end
        return res;
    endfunction

    task automatic check(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, want %h", nm, k, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input int k, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %b, want %b", nm, k, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, want %0d", nm, k, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input int k);
        n_cmp++;
        n_fail++;
        $display("FAIL %s dut%0d: bound expired or unexpected event", nm, k);
    endtask

    // Scoreboard state, one ring per instance.
    logic [127:0] sb [3][16];
    int           wr  [3] = '{0, 0, 0};
    int           rd  [3] = '{0, 0, 0};
    int           cyc [3] = '{0, 0, 0};
    bit           pend [3] = '{0, 0, 0};
    bit           held [3] = '{0, 0, 0};
    logic [127:0] held_val [3];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n[k]) begin
                rd[k]   = wr[k];
                pend[k] = 1'b0;
                held[k] = 1'b0;
            end else begin
                if (held[k]) begin
                    check_bit("hold_valid", k, out_valid[k], 1'b1);
                    check("hold_data", k, dout[k], held_val[k]);
                end
                if (pend[k]) begin
                    cyc[k]++;
                    if (out_valid[k]) begin
                        check_int("latency", k, cyc[k], LAT[k]);
                        pend[k] = 1'b0;
                    end else if (cyc[k] > 8) begin
                        fail_now("latency_timeout", k);
                        pend[k] = 1'b0;
                    end
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (rd[k] == wr[k]) fail_now("stray_output", k);
                    else begin
                        check("result", k, dout[k], sb[k][rd[k] % 16]);
                        rd[k]++;
                    end
                end
                held[k]     = out_valid[k] && !out_ready[k];
                held_val[k] = dout[k];
                if (in_valid[k] && in_ready[k]) begin
                    sb[k][wr[k] % 16] = mix_model(din[k], mode[k]);
                    wr[k]++;
                    pend[k] = 1'b1;
                    cyc[k]  = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[k]) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("accept_timeout", k);
        tick();
    endtask

    task automatic wait_out(input int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[k]) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("output_timeout", k);
    endtask

    task automatic transact(input int k, input logic [127:0] x, input logic m, output logic [127:0] y);
        in_valid[k] = 1'b1; din[k] = x; mode[k] = m; out_ready[k] = 1'b0;
        wait_accept(k);
        in_valid[k] = 1'b0;
        din[k]  = {$urandom, $urandom, $urandom, $urandom};
        mode[k] = ~m;
        wait_out(k);
        y = dout[k];
        tick();
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
    endtask

    task automatic run_dut(input int k);
        logic [127:0] y;
        logic [127:0] z;
        logic [127:0] x;
        int           c;
        int           target;

        // Reset while in_valid is high: nothing accepted, outputs cleared.
        tick();
        rst_n[k] = 1'b0; in_valid[k] = 1'b1; din[k] = S_PLAIN;
        tick();
        @(negedge clk);
        check_bit("rst_in_ready", k, in_ready[k], 1'b0);
        check_bit("rst_out_valid", k, out_valid[k], 1'b0);
        check("rst_data_out", k, dout[k], 128'h0);
        tick();
        rst_n[k] = 1'b1; in_valid[k] = 1'b0;
        @(negedge clk);
        check_bit("idle_in_ready", k, in_ready[k], 1'b1);
        check_bit("idle_out_valid", k, out_valid[k], 1'b0);
        tick();

        transact(k, S_PLAIN, 1'b0, y);   check("fwd_state", k, y, S_MIX);
        transact(k, S_MIX, 1'b1, y);     check("inv_state", k, y, S_PLAIN);
        transact(k, COLV_IN, 1'b0, y);   check("fwd_cols", k, y, COLV_OUT);
        transact(k, COLV_OUT, 1'b1, y);  check("inv_cols", k, y, COLV_IN);

        // Backpressure, then back-to-back accept on the output handshake.
        in_valid[k] = 1'b1; din[k] = S_PLAIN; mode[k] = 1'b0; out_ready[k] = 1'b0;
        wait_accept(k);
        in_valid[k] = 1'b0;
        wait_out(k);
        tick();
        in_valid[k] = 1'b1; din[k] = S_MIX; mode[k] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("bp_out_valid", k, out_valid[k], 1'b1);
            check("bp_data", k, dout[k], S_MIX);
            check_bit("bp_in_ready", k, in_ready[k], 1'b0);
        end
        tick();
        out_ready[k] = 1'b1;
        @(negedge clk);
        check_bit("b2b_in_ready", k, in_ready[k], 1'b1);
        tick();
        in_valid[k] = 1'b0;
        @(negedge clk);
        check_bit("b2b_gap", k, out_valid[k], 1'b0);
        wait_out(k);
        check("b2b_result", k, dout[k], S_PLAIN);
        tick();
        out_ready[k] = 1'b0;
        tick();

        // Reset in the middle of a transaction.
        in_valid[k] = 1'b1; din[k] = S_PLAIN; mode[k] = 1'b0;
        wait_accept(k);
        in_valid[k] = 1'b0; rst_n[k] = 1'b0;
        tick();
        @(negedge clk);
        check_bit("midrst_out_valid", k, out_valid[k], 1'b0);
        check("midrst_data_out", k, dout[k], 128'h0);
        check_bit("midrst_in_ready", k, in_ready[k], 1'b0);
        tick();
        rst_n[k] = 1'b1;
        @(negedge clk);
        check_bit("postrst_in_ready", k, in_ready[k], 1'b1);
        tick();
        transact(k, COLV_IN, 1'b0, y);   check("postrst_result", k, y, COLV_OUT);

        // Forward then inverse through the DUT must restore the input.
        for (int i = 0; i < 4; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            transact(k, x, 1'b0, y);
            transact(k, y, 1'b1, z);
            check("roundtrip", k, z, x);
        end

        // Random traffic with random handshakes.
        c = 0;
        target = wr[k] + 1000;
        while (wr[k] < target && c < 30000) begin
            tick();
            in_valid[k]  = 1'($urandom_range(0, 1));
            din[k]       = {$urandom, $urandom, $urandom, $urandom};
            mode[k]      = 1'($urandom_range(0, 1));
            out_ready[k] = 1'($urandom_range(0, 1));
            c++;
        end
        if (c >= 30000) fail_now("random_budget", k);
        in_valid[k] = 1'b0; out_ready[k] = 1'b1;
        repeat (8) tick();
        check_int("drain_count", k, rd[k], wr[k]);
        out_ready[k] = 1'b0;
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b0; mode[k] = 1'b0;
            out_ready[k] = 1'b0; din[k] = '0;
        end
        check("model_fwd_state", 0, mix_model(S_PLAIN, 1'b0), S_MIX);
        check("model_inv_state", 0, mix_model(S_MIX, 1'b1), S_PLAIN);
        check("model_fwd_cols", 0, mix_model(COLV_IN, 1'b0), COLV_OUT);
        check("model_inv_cols", 0, mix_model(COLV_OUT, 1'b1), COLV_IN);
        repeat (3) tick();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) run_dut(k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
